// File: rtl/ctrl_cmd_driver.sv
// Control-interface initiator: queues {len, word} commands and drives each beat as a one-cycle enable strobe.
// Latency: a push into an empty queue strobes enable two edges later; cmd_ready drops only when the queue is full.
module ctrl_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [31:0]                  cmd_word,
  input  logic [3:0]                   cmd_len,
  output logic                         enable,
  output logic [7:0]                   op_code,
  output logic [7:0]                   address,
  output logic [15:0]                  data,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  len;
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q, state_d;
  logic          enable_q, enable_d;
  logic          done_q, done_d;
  logic [7:0]    op_q, op_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic [3:0]    beats_q, beats_d;
  logic [GW-1:0] gap_q, gap_d;

  logic full, empty, push, pop, load, step;
  cmd_t head, cmd_in;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem_q[rd_ptr_q];
  assign cmd_in    = '{len: cmd_len, op: cmd_word[31:24], addr: cmd_word[23:16], data: cmd_word[15:0]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // load = pop a new command and present its first beat; step = next beat of the current burst
  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    done_d   = done_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    beats_d  = beats_q;
    gap_d    = gap_q;
    pop      = 1'b0;
    load     = 1'b0;
    step     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) load = 1'b1;
      end
      S_DRIVE: begin
        if (GAP > 0) begin
          enable_d = 1'b0;
          done_d   = 1'b0;
          gap_d    = GW'(GAP - 1);
          state_d  = S_GAP;
        end else if (beats_q != 4'd0) begin
          step = 1'b1;
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          enable_d = 1'b0;
          done_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (beats_q != 4'd0) begin
          step = 1'b1;
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        enable_d = 1'b0;
        done_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    if (load) begin
      pop      = 1'b1;
      op_d     = head.op;
      addr_d   = head.addr;
      data_d   = head.data;
      beats_d  = (head.len == 4'd0) ? 4'd0 : head.len - 4'd1;
      done_d   = (head.len <= 4'd1);
      enable_d = 1'b1;
      state_d  = S_DRIVE;
    end

    if (step) begin
      addr_d   = addr_q + 8'd1;
      beats_d  = beats_q - 4'd1;
      done_d   = (beats_q == 4'd1);
      enable_d = 1'b1;
      state_d  = S_DRIVE;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      op_q     <= 8'hff;
      addr_q   <= 8'hff;
      data_q   <= 16'hffff;
      beats_q  <= 4'd0;
      gap_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      enable_q <= enable_d;
      done_q   <= done_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      beats_q  <= beats_d;
      gap_q    <= gap_d;
    end
  end

  assign enable     = enable_q;
  assign done       = done_q;
  assign op_code    = op_q;
  assign address    = addr_q;
  assign data       = data_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_ctrl_cmd_driver.sv
// Three drivers (GAP = 0, 1, 2) share one stimulus stream; each is checked every cycle against a beat-list model.
module tb_ctrl_cmd_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_word = '0;
  logic [3:0]  cmd_len = '0;
  bit          chk_on = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          acc [3];

  logic        rdy_w [3];
  logic        en_w  [3];
  logic        dn_w  [3];
  logic        bsy_w [3];
  logic [7:0]  op_w  [3];
  logic [7:0]  ad_w  [3];
  logic [15:0] dt_w  [3];
  logic [2:0]  cnt_w [3];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    ctrl_cmd_driver #(.DEPTH(4), .GAP(g)) dut (
      .clk(clk), .reset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(rdy_w[g]),
      .cmd_word(cmd_word), .cmd_len(cmd_len),
      .enable(en_w[g]), .op_code(op_w[g]), .address(ad_w[g]), .data(dt_w[g]),
      .busy(bsy_w[g]), .done(dn_w[g]), .fifo_count(cnt_w[g])
    );

    // Model: queued commands, plus the expanded beats of the command being driven and a cooldown counter.
    logic [35:0] q [$];
    logic [31:0] beats [$];
    int          cool = 0;
    bit          m_en = 1'b0, m_dn = 1'b0, m_gw = 1'b0, m_acc;
    logic [7:0]  m_op = 8'hff, m_ad = 8'hff;
    logic [15:0] m_dt = 16'hffff;
    logic [35:0] m_c;
    logic [31:0] m_b;
    int          m_n;

    always begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        beats.delete();
        cool = 0;
        m_en = 1'b0; m_dn = 1'b0; m_gw = 1'b0;
        m_op = 8'hff; m_ad = 8'hff; m_dt = 16'hffff;
      end else begin
        m_acc = cmd_valid && (q.size() < 4);
        m_en = 1'b0; m_dn = 1'b0; m_gw = 1'b0;
        if (cool > 0) begin
          cool--;
          m_gw = 1'b1;
        end else begin
          if (beats.size() == 0 && q.size() > 0) begin
            m_c = q.pop_front();
            m_n = (m_c[35:32] == 4'd0) ? 1 : int'(m_c[35:32]);
            for (int i = 0; i < m_n; i++)
              beats.push_back({m_c[31:24], m_c[23:16] + 8'(i), m_c[15:0]});
          end
          if (beats.size() > 0) begin
            m_b = beats.pop_front();
            m_en = 1'b1;
            m_dn = (beats.size() == 0);
            {m_op, m_ad, m_dt} = m_b;
            cool = g;
          end
        end
        if (m_acc) q.push_back({cmd_len, cmd_word});
      end
    end

    always @(negedge clk) begin
      if (chk_on) begin
        chk($sformatf("g%0d enable", g), 32'(en_w[g]), 32'(m_en));
        chk($sformatf("g%0d done", g), 32'(dn_w[g]), 32'(m_dn));
        chk($sformatf("g%0d op_code", g), 32'(op_w[g]), 32'(m_op));
        chk($sformatf("g%0d address", g), 32'(ad_w[g]), 32'(m_ad));
        chk($sformatf("g%0d data", g), 32'(dt_w[g]), 32'(m_dt));
        chk($sformatf("g%0d busy", g), 32'(bsy_w[g]), 32'(m_en || m_gw || q.size() != 0));
        chk($sformatf("g%0d cmd_ready", g), 32'(rdy_w[g]), 32'(q.size() != 4));
        chk($sformatf("g%0d fifo_count", g), 32'(cnt_w[g]), 32'(q.size()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_reset_image(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s g%0d enable", tag, g), 32'(en_w[g]), 32'd0);
      chk($sformatf("%s g%0d done", tag, g), 32'(dn_w[g]), 32'd0);
      chk($sformatf("%s g%0d op", tag, g), 32'(op_w[g]), 32'hff);
      chk($sformatf("%s g%0d addr", tag, g), 32'(ad_w[g]), 32'hff);
      chk($sformatf("%s g%0d data", tag, g), 32'(dt_w[g]), 32'hffff);
      chk($sformatf("%s g%0d count", tag, g), 32'(cnt_w[g]), 32'd0);
      chk($sformatf("%s g%0d busy", tag, g), 32'(bsy_w[g]), 32'd0);
      chk($sformatf("%s g%0d ready", tag, g), 32'(rdy_w[g]), 32'd1);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic [3:0] l);
    cmd_valid = 1'b1;
    cmd_word  = w;
    cmd_len   = l;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 check_reset_image("reset");
    chk_on = 1'b1;
    tick(); tick();
    #3 rst = 1'b0;

    // single command, checked on the GAP=1 driver
    tick();
    push(32'h0120_ABCD, 4'd0);
    tick();
    cmd_valid = 1'b0;
    chk("single count after push", 32'(cnt_w[1]), 32'd1);
    chk("single no bypass", 32'(en_w[1]), 32'd0);
    tick();
    chk("single enable", 32'(en_w[1]), 32'd1);
    chk("single op", 32'(op_w[1]), 32'h01);
    chk("single addr", 32'(ad_w[1]), 32'h20);
    chk("single data", 32'(dt_w[1]), 32'hABCD);
    chk("single done", 32'(dn_w[1]), 32'd1);
    tick();
    chk("single enable low", 32'(en_w[1]), 32'd0);
    chk("single addr held", 32'(ad_w[1]), 32'h20);
    chk("single done low", 32'(dn_w[1]), 32'd0);
    tick(); tick();
    chk("single busy idle", 32'(bsy_w[1]), 32'd0);
    idle(20);

    // address-wrapping burst on the GAP=0 driver
    push(32'h02FE_1234, 4'd3);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("burst b1 en", 32'(en_w[0]), 32'd1);
    chk("burst b1 addr", 32'(ad_w[0]), 32'hFE);
    chk("burst b1 done", 32'(dn_w[0]), 32'd0);
    tick();
    chk("burst b2 en", 32'(en_w[0]), 32'd1);
    chk("burst b2 addr", 32'(ad_w[0]), 32'hFF);
    chk("burst b2 data", 32'(dt_w[0]), 32'h1234);
    chk("burst b2 done", 32'(dn_w[0]), 32'd0);
    tick();
    chk("burst b3 en", 32'(en_w[0]), 32'd1);
    chk("burst b3 addr", 32'(ad_w[0]), 32'h00);
    chk("burst b3 done", 32'(dn_w[0]), 32'd1);
    tick();
    chk("burst end en", 32'(en_w[0]), 32'd0);
    chk("burst end addr held", 32'(ad_w[0]), 32'h00);
    idle(20);

    // two singles on the GAP=2 driver: enable 1,0,0,1
    push(32'h0310_1111, 4'd1);
    tick();
    push(32'h0411_2222, 4'd0);
    tick();
    cmd_valid = 1'b0;
    chk("gap c1 en", 32'(en_w[2]), 32'd1);
    chk("gap c1 addr", 32'(ad_w[2]), 32'h10);
    tick();
    chk("gap slot1 en", 32'(en_w[2]), 32'd0);
    chk("gap slot1 addr held", 32'(ad_w[2]), 32'h10);
    tick();
    chk("gap slot2 en", 32'(en_w[2]), 32'd0);
    chk("gap slot2 op held", 32'(op_w[2]), 32'h03);
    tick();
    chk("gap c2 en", 32'(en_w[2]), 32'd1);
    chk("gap c2 op", 32'(op_w[2]), 32'h04);
    chk("gap c2 addr", 32'(ad_w[2]), 32'h11);
    chk("gap c2 data", 32'(dt_w[2]), 32'h2222);
    idle(20);

    // fill the queue behind a long burst
    push(32'h0500_0000, 4'd15);
    tick();
    for (int g = 0; g < 3; g++) acc[g] = 0;
    for (int i = 0; i < 6; i++) begin
      push({8'h06, 8'(8'h40 + i), 16'(i)}, 4'(i % 4));
      for (int g = 0; g < 3; g++) if (rdy_w[g]) acc[g]++;
      tick();
    end
    cmd_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("full g%0d accepted", g), 32'(acc[g]), 32'd4);
      chk($sformatf("full g%0d count", g), 32'(cnt_w[g]), 32'd4);
      chk($sformatf("full g%0d ready", g), 32'(rdy_w[g]), 32'd0);
    end
    idle(150);

    // reset in the middle of a burst with a command queued behind it
    push(32'h0730_5555, 4'd10);
    tick();
    push(32'h0899_7777, 4'd2);
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("mid-burst b3 en", 32'(en_w[0]), 32'd1);
    chk("mid-burst b3 addr", 32'(ad_w[0]), 32'h32);
    #2 rst = 1'b1;
    #1 check_reset_image("async reset");
    tick();
    chk("reset held en", 32'(en_w[0]), 32'd0);
    #3 rst = 1'b0;
    tick();
    push(32'h0950_6666, 4'd0);
    tick();
    cmd_valid = 1'b0;
    chk("post-reset no bypass", 32'(en_w[0]), 32'd0);
    tick();
    chk("post-reset en", 32'(en_w[0]), 32'd1);
    chk("post-reset addr", 32'(ad_w[0]), 32'h50);
    chk("post-reset data", 32'(dt_w[0]), 32'h6666);
    idle(10);

    // random traffic with occasional mid-cycle resets
    for (int i = 0; i < 700; i++) begin
      cmd_valid = ($urandom_range(0, 99) < 40);
      cmd_word  = $urandom();
      cmd_len   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      if ($urandom_range(0, 249) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
      tick();
    end
    cmd_valid = 1'b0;
    idle(200);
    for (int g = 0; g < 3; g++)
      chk($sformatf("drain g%0d busy", g), 32'(bsy_w[g]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_cmd_driver.md
Name: ctrl_cmd_driver

Overview:
- Initiator side of the control interface: the block that produces the clk/reset/enable/address/op_code/data traffic that the ctrl register block latches.
- Software-side command words are buffered in a small FIFO.
- Each command is driven onto the interface as one-cycle enable strobes with configurable idle gaps.
- Supports short address-incrementing bursts.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2).
- GAP, 1, idle (enable low) cycles inserted after every beat; 0 = back-to-back beats.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- cmd_valid  input  1  command word offered.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_word  input  32  [31:24] op_code, [23:16] address, [15:0] data.
- cmd_len  input  4  burst beats; 0 and 1 both mean a single beat; max 15.
- enable  output  1  interface strobe; high exactly one cycle per beat.
- op_code  output  8  interface op_code.
- address  output  8  interface address.
- data  output  16  interface data.
- busy  output  1  high while FSM not IDLE or FIFO non-empty.
- done  output  1  one-cycle pulse coincident with enable of a command's last beat.
- fifo_count  output  $clog2(DEPTH+1)  occupied FIFO entries.

Behaviour:
- Reset (async, active-high), applied while reset is high:
  - enable=0, done=0, op_code=8'hff, address=8'hff, data=16'hffff. These match the receiver's reset image.
  - FIFO flushed, fifo_count=0, cmd_ready=1 (DEPTH>0), FSM=IDLE, busy=0.
- Reset mid-burst or mid-gap:
  - Aborts immediately; remaining beats and queued commands are discarded.
  - No enable is asserted while reset is high.
- Push:
  - cmd_valid && cmd_ready at a rising edge writes {cmd_len, cmd_word} into the FIFO.
  - cmd_ready is !full only. A push is refused when full, even if a pop occurs the same edge.
- FIFO: circular pointers with wrap at DEPTH; fifo_count updates on the edge of push or pop; a simultaneous push and pop (non-full) leaves fifo_count unchanged.
- FSM states are IDLE, DRIVE and GAP.
  - IDLE -> DRIVE: at an edge where the FIFO is non-empty.
    - Pop the head; drive op_code/address/data from it; enable<=1.
    - beats_left<=max(len,1)-1; done<=(beats_left==0).
  - DRIVE (enable high this cycle). At the next edge:
    - If GAP>0: enable<=0, done<=0, gap_cnt<=GAP-1, go to GAP.
    - If GAP==0 and beats_left>0: address<=address+1 (8-bit wrap 8'hff->8'h00); op_code and data unchanged; beats_left decrements; enable stays 1; done set on the last beat.
    - If GAP==0, beats_left==0 and FIFO non-empty: pop the next command and continue as in the IDLE->DRIVE transition, back to back.
    - Otherwise: enable<=0, done<=0, go to IDLE.
  - GAP (enable low). At each edge gap_cnt decrements. When gap_cnt==0 at an edge:
    - If beats_left>0: address+1, enable<=1, go to DRIVE.
    - Else if the FIFO is non-empty: pop and drive as in IDLE.
    - Else: go to IDLE.
- Interface fields hold their last driven values whenever enable is low. They change only on the edge that raises enable, or on a burst increment.
- Latency, empty FIFO and IDLE: command pushed at edge N; popped at edge N+1; enable is high in the cycle following edge N+1.
- A push into an empty FIFO is not popped on the same edge (no bypass).
- busy is combinational: (state!=IDLE) || (fifo_count!=0).
- Each beat presents exactly one enable cycle. A receiver that samples on enable sees exactly max(len,1) writes per command.

Test Plan:
- Reset values: assert reset mid-cycle (async) -> outputs immediately 0/8'hff/8'hff/16'hffff, fifo_count=0, busy=0, cmd_ready=1.
- Single command, GAP=1: push 32'h01_20_ABCD, len=0 at edge N.
  - Response: enable=1 for one cycle after edge N+1 with op=01, addr=20, data=ABCD, done=1.
  - Then enable=0 and outputs held; busy falls after that cycle.
- Burst wrap, GAP=0: push 32'h02_FE_1234, len=3.
  - Response: 3 consecutive enable cycles with addresses FE, FF, 00, data 1234 each; done only on the third.
- Gap spacing, GAP=2: two single commands pushed back to back.
  - Response: enable pattern 1,0,0,1; second command's fields appear only on its enable edge.
- Full FIFO, DEPTH=4, driver busy in a long burst: hold cmd_valid for 6 cycles.
  - Response: exactly 4 accepted, cmd_ready=0 at fifo_count=4, push refused on the pop edge.
  - All 4 accepted commands are later driven in order.
- Reset mid-burst: len=10, reset asserted after the 3rd beat.
  - Response: enable drops immediately, FIFO empties, no further beats.
  - After reset, a new command drives normally with the 2-cycle latency.
